bf_engine: RTL and testbench

Parametrised Brainfuck execution core, successor to the fixed 8-bit machine. It fetches 4-bit opcodes from an external synchronous program memory and executes them against an internal data array of `2**DAW` cells, each `DOW` bits wide. Loops resolve through a hardware bracket stack, so backward jumps take one cycle instead of a bracket scan. Character I/O uses valid/ready handshakes. It is the execution engine beneath the board-level top.

---
 rtl/bf_pkg.sv | 28 ++
 rtl/bf_loop_stack.sv | 60 ++++++
 rtl/bf_engine.sv | 236 +++++++++++++++++++++++
 tb/tb_bf_engine.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// bf_pkg: shared opcode constants and FSM state encoding for bf_engine.
// Imported by bf_engine and bf_loop_stack.
package bf_pkg;

  localparam logic [3:0] OP_HALT  = 4'd0;
  localparam logic [3:0] OP_INC   = 4'd1;
  localparam logic [3:0] OP_DEC   = 4'd2;
  localparam logic [3:0] OP_RIGHT = 4'd3;
  localparam logic [3:0] OP_LEFT  = 4'd4;
  localparam logic [3:0] OP_OPEN  = 4'd5;
  localparam logic [3:0] OP_CLOSE = 4'd6;
  localparam logic [3:0] OP_OUT   = 4'd7;
  localparam logic [3:0] OP_IN    = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CLEAR    = 4'd1,
    S_FETCH    = 4'd2,
    S_EXEC     = 4'd3,
    S_SKIP_F   = 4'd4,
    S_SKIP_E   = 4'd5,
    S_WAIT_IN  = 4'd6,
    S_WAIT_OUT = 4'd7,
    S_DONE     = 4'd8,
    S_ERROR    = 4'd9
  } state_e;

endpackage

// File: rtl/bf_loop_stack.sv
// bf_loop_stack: DEPTH x AW LIFO holding the pc of each open '['.
// Ports: clr (sync flush), push/push_data, pop, top, full, empty.
module bf_loop_stack
  import bf_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] ptr_m1;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [AW-1:0] mem_q [DEPTH];
  logic          do_push;

  assign full    = (ptr_q == PW'(DEPTH));
  assign empty   = (ptr_q == '0);
  assign ptr_m1  = ptr_q - PW'(1);
  assign wr_idx  = ptr_q[IW-1:0];
  assign rd_idx  = ptr_m1[IW-1:0];
  assign top     = empty ? '0 : mem_q[rd_idx];
  assign do_push = push && !full && !clr;

  always_comb begin
    ptr_d = ptr_q;
    if (clr)
      ptr_d = '0;
    else if (push && !full)
      ptr_d = ptr_q + PW'(1);
    else if (pop && !empty)
      ptr_d = ptr_m1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (do_push)
        mem_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/bf_engine.sv
// bf_engine: Brainfuck execution core with bracket stack and
// valid/ready char I/O; pm_* program port, in_*/out_* streams, debug.
module bf_engine
  import bf_pkg::*;
#(
  parameter int PMAW        = 8,
  parameter int DAW         = 8,
  parameter int DOW         = 8,
  parameter int STACK_DEPTH = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            go,
  output logic [PMAW-1:0] pm_addr,
  input  logic [3:0]      pm_data,
  input  logic [DOW-1:0]  in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [DOW-1:0]  out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [3:0]      state,
  output logic [PMAW-1:0] pc,
  output logic [DAW-1:0]  dp
);

  localparam int CELLS = 2 ** DAW;

  state_e          state_q, state_d;
  logic [PMAW-1:0] pc_q, pc_d;
  logic [DAW-1:0]  dp_q, dp_d;
  logic [PMAW-1:0] depth_q, depth_d;
  logic [DAW-1:0]  clr_q, clr_d;

  logic [DOW-1:0]  cell_q [CELLS];
  logic            cell_we;
  logic [DAW-1:0]  cell_wa;
  logic [DOW-1:0]  cell_wd;
  logic [DOW-1:0]  cur;
  logic            cur_zero;

  logic            st_clr;
  logic            st_push;
  logic            st_pop;
  logic [PMAW-1:0] st_top;
  logic            st_full;
  logic            st_empty;

  assign cur      = cell_q[dp_q];
  assign cur_zero = (cur == '0);

  bf_loop_stack #(
    .AW    (PMAW),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clock),
    .rst_n     (reset),
    .clr       (st_clr),
    .push      (st_push),
    .pop       (st_pop),
    .push_data (pc_q),
    .top       (st_top),
    .full      (st_full),
    .empty     (st_empty)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    dp_d    = dp_q;
    depth_d = depth_q;
    clr_d   = clr_q;
    cell_we = 1'b0;
    cell_wa = dp_q;
    cell_wd = cur;
    st_clr  = 1'b0;
    st_push = 1'b0;
    st_pop  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go)
          state_d = S_FETCH;
      end
      S_DONE, S_ERROR: begin
        if (go) begin
          state_d = S_CLEAR;
          pc_d    = '0;
          dp_d    = '0;
          depth_d = '0;
          clr_d   = '0;
          st_clr  = 1'b1;
        end
      end
      S_CLEAR: begin
        cell_we = 1'b1;
        cell_wa = clr_q;
        cell_wd = '0;
        clr_d   = clr_q + DAW'(1);
        if (clr_q == '1)
          state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + PMAW'(1);
        case (pm_data)
          OP_HALT: begin
            state_d = S_DONE;
            pc_d    = pc_q;
          end
          OP_INC: begin
            cell_we = 1'b1;
            cell_wd = cur + DOW'(1);
          end
          OP_DEC: begin
            cell_we = 1'b1;
            cell_wd = cur - DOW'(1);
          end
          OP_RIGHT: dp_d = dp_q + DAW'(1);
          OP_LEFT:  dp_d = dp_q - DAW'(1);
          OP_OPEN: begin
            if (cur_zero) begin
              // scan starts at the opcode after '['
              depth_d = PMAW'(1);
              state_d = S_SKIP_F;
            end else if (st_full) begin
              state_d = S_ERROR;
              pc_d    = pc_q;
            end else begin
              st_push = 1'b1;
            end
          end
          OP_CLOSE: begin
            if (st_empty) begin
              state_d = S_ERROR;
              pc_d    = pc_q;
            end else if (!cur_zero) begin
              // resume just past the matching '['
              pc_d = st_top + PMAW'(1);
            end else begin
              st_pop = 1'b1;
            end
          end
          OP_OUT: begin
            state_d = S_WAIT_OUT;
            pc_d    = pc_q;
          end
          OP_IN: begin
            state_d = S_WAIT_IN;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end
      S_SKIP_F: begin
        state_d = S_SKIP_E;
      end
      S_SKIP_E: begin
        pc_d    = pc_q + PMAW'(1);
        state_d = S_SKIP_F;
        case (pm_data)
          OP_HALT: begin
            state_d = S_ERROR;
            pc_d    = pc_q;
          end
          OP_OPEN:  depth_d = depth_q + PMAW'(1);
          OP_CLOSE: begin
            depth_d = depth_q - PMAW'(1);
            if (depth_q == PMAW'(1))
              state_d = S_FETCH;
          end
          default: ;
        endcase
      end
      S_WAIT_OUT: begin
        if (out_ready) begin
          pc_d    = pc_q + PMAW'(1);
          state_d = S_FETCH;
        end
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          cell_we = 1'b1;
          cell_wd = in_data;
          pc_d    = pc_q + PMAW'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      dp_q    <= '0;
      depth_q <= '0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      dp_q    <= dp_d;
      depth_q <= depth_d;
      clr_q   <= clr_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CELLS; i++)
        cell_q[i] <= '0;
    end else if (cell_we) begin
      cell_q[cell_wa] <= cell_wd;
    end
  end

  assign pm_addr   = pc_q;
  assign pc        = pc_q;
  assign dp        = dp_q;
  assign state     = state_q;
  assign out_valid = (state_q == S_WAIT_OUT);
  assign out_data  = out_valid ? cur : '0;
  assign in_ready  = (state_q == S_WAIT_IN);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);
  assign busy      = !((state_q == S_IDLE) ||
                       (state_q == S_DONE) ||
                       (state_q == S_ERROR));

endmodule

// File: tb/tb_bf_engine.sv
// tb_bf_engine: directed self-checking bench for bf_engine
// with a synchronous program ROM model.
module tb_bf_engine;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       go = 1'b0;
  logic [7:0] pm_addr;
  logic [3:0] pm_data = 4'd0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy, done, error;
  logic [3:0] state;
  logic [7:0] pc, dp;

  logic [3:0] pmem [256];

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  always_ff @(posedge clock)
    pm_data <= pmem[pm_addr];

  bf_engine dut (
    .clock     (clock),
    .reset     (reset),
    .go        (go),
    .pm_addr   (pm_addr),
    .pm_data   (pm_data),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .state     (state),
    .pc        (pc),
    .dp        (dp)
  );

  function automatic logic [3:0] opc(input byte c);
    case (c)
      "+": return 4'd1;
      "-": return 4'd2;
      ">": return 4'd3;
      "<": return 4'd4;
      "[": return 4'd5;
      "]": return 4'd6;
      ".": return 4'd7;
      ",": return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  task automatic load(input string p);
    for (int i = 0; i < 256; i++)
      pmem[i] = 4'd0;
    for (int i = 0; i < p.len(); i++)
      pmem[i] = opc(p[i]);
  endtask

  task automatic pulse_go();
    @(negedge clock) go = 1'b1;
    @(negedge clock) go = 1'b0;
  endtask

  // runs until done/error or cycle budget, logging accepted outputs
  task automatic run(input string p, output int cyc,
                     output int nout, output logic [7:0] last);
    load(p);
    out_ready = 1'b1;
    pulse_go();
    cyc = 0;
    nout = 0;
    last = 8'd0;
    while (!done && !error && cyc < 2000) begin
      if (out_valid && out_ready) begin
        nout++;
        last = out_data;
      end
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic test_reset();
    #12;
    nvec++;
    if ({busy, done, error, out_valid, in_ready} !== 5'b0) begin
      nerr++;
      $display("FAIL reset_flags: got %b expected 00000",
               {busy, done, error, out_valid, in_ready});
    end
    nvec++;
    if ({state, pc, dp, out_data, pm_addr} !== 36'h0) begin
      nerr++;
      $display("FAIL reset_regs: got %h expected 0",
               {state, pc, dp, out_data, pm_addr});
    end
    @(negedge clock) reset = 1'b1;
  endtask

  task automatic test_output();
    int cyc, nout;
    logic [7:0] last;
    run("++++.", cyc, nout, last);
    nvec++;
    if (nout !== 1 || last !== 8'd4) begin
      nerr++;
      $display("FAIL out_plus4: got n=%0d d=%0d expected n=1 d=4",
               nout, last);
    end
    nvec++;
    if (done !== 1'b1 || cyc < 12 || cyc > 13) begin
      nerr++;
      $display("FAIL out_done: got done=%b cyc=%0d expected 1 12..13",
               done, cyc);
    end
  endtask

  task automatic test_input();
    int cyc;
    int nout = 0;
    logic [7:0] last = 8'd0;
    bit hold_ok = 1'b1;
    load(",-.");
    out_ready = 1'b1;
    pulse_go();
    nvec++;
    if (in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL in_early: got %b expected 0", in_ready);
    end
    cyc = 0;
    while (!in_ready && cyc < 400) begin
      @(negedge clock);
      cyc++;
    end
    nvec++;
    if (in_ready !== 1'b1 || state !== 4'd6) begin
      nerr++;
      $display("FAIL in_wait: got rdy=%b st=%0d expected 1 6",
               in_ready, state);
    end
    repeat (5) begin
      @(negedge clock);
      if (in_ready !== 1'b1) hold_ok = 1'b0;
    end
    nvec++;
    if (hold_ok !== 1'b1) begin
      nerr++;
      $display("FAIL in_hold: got %b expected 1", hold_ok);
    end
    in_data = 8'h41;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    nvec++;
    if (in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL in_after: got %b expected 0", in_ready);
    end
    cyc = 0;
    while (!done && !error && cyc < 100) begin
      if (out_valid && out_ready) begin
        nout++;
        last = out_data;
      end
      @(negedge clock);
      cyc++;
    end
    nvec++;
    if (done !== 1'b1 || nout !== 1 || last !== 8'h40) begin
      nerr++;
      $display("FAIL in_echo: got done=%b n=%0d d=%h expected 1 1 40",
               done, nout, last);
    end
  endtask

  task automatic test_loop();
    int cyc, nout;
    logic [7:0] last;
    run("+++[->++<]>.", cyc, nout, last);
    nvec++;
    if (done !== 1'b1 || nout !== 1 || last !== 8'd6) begin
      nerr++;
      $display("FAIL loop_mul: got done=%b n=%0d d=%0d expected 1 1 6",
               done, nout, last);
    end
    nvec++;
    if (dut.u_stack.empty !== 1'b1) begin
      nerr++;
      $display("FAIL loop_stack: got empty=%b expected 1",
               dut.u_stack.empty);
    end
  endtask

  task automatic test_skip();
    int cyc, nout;
    logic [7:0] last;
    run("[+++]+.", cyc, nout, last);
    nvec++;
    if (done !== 1'b1 || nout !== 1 || last !== 8'd1) begin
      nerr++;
      $display("FAIL skip_fwd: got done=%b n=%0d d=%0d expected 1 1 1",
               done, nout, last);
    end
    run("[[", cyc, nout, last);
    nvec++;
    if (error !== 1'b1 || done !== 1'b0) begin
      nerr++;
      $display("FAIL skip_unmatched: got err=%b done=%b expected 1 0",
               error, done);
    end
  endtask

  task automatic test_wrap();
    int cyc, nout;
    logic [7:0] last;
    run("-.", cyc, nout, last);
    nvec++;
    if (nout !== 1 || last !== 8'd255) begin
      nerr++;
      $display("FAIL wrap_cell: got n=%0d d=%0d expected 1 255",
               nout, last);
    end
    run("<", cyc, nout, last);
    nvec++;
    if (done !== 1'b1 || dp !== 8'd255) begin
      nerr++;
      $display("FAIL wrap_dp: got done=%b dp=%0d expected 1 255",
               done, dp);
    end
  endtask

  task automatic test_clear();
    int cyc, nout;
    logic [7:0] last;
    run("---", cyc, nout, last);
    run(".", cyc, nout, last);
    nvec++;
    if (done !== 1'b1 || nout !== 1 || last !== 8'd0 || cyc < 256) begin
      nerr++;
      $display("FAIL clear_cells: got n=%0d d=%0d cyc=%0d expected 1 0 >=256",
               nout, last, cyc);
    end
  endtask

  task automatic test_stack_limits();
    int cyc, nout;
    logic [7:0] last;
    string s;
    s = "+";
    for (int i = 0; i < 16; i++)
      s = {s, "["};
    s = {s, "-]"};
    for (int i = 0; i < 15; i++)
      s = {s, "]"};
    run(s, cyc, nout, last);
    nvec++;
    if (done !== 1'b1 || error !== 1'b0) begin
      nerr++;
      $display("FAIL nest16: got done=%b err=%b expected 1 0", done, error);
    end
    s = "+";
    for (int i = 0; i < 17; i++)
      s = {s, "["};
    run(s, cyc, nout, last);
    nvec++;
    if (error !== 1'b1 || pc !== 8'd17) begin
      nerr++;
      $display("FAIL nest17: got err=%b pc=%0d expected 1 17", error, pc);
    end
    run("]", cyc, nout, last);
    nvec++;
    if (error !== 1'b1 || pc !== 8'd0) begin
      nerr++;
      $display("FAIL lone_close: got err=%b pc=%0d expected 1 0", error, pc);
    end
  endtask

  task automatic test_reset_mid_out();
    int cyc, nout;
    logic [7:0] last;
    load("+.");
    out_ready = 1'b0;
    pulse_go();
    cyc = 0;
    while (!out_valid && cyc < 400) begin
      @(negedge clock);
      cyc++;
    end
    nvec++;
    if (out_valid !== 1'b1 || out_data !== 8'd1) begin
      nerr++;
      $display("FAIL rst_pre: got v=%b d=%0d expected 1 1",
               out_valid, out_data);
    end
    #2 reset = 1'b0;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || state !== 4'd0 || pc !== 8'd0) begin
      nerr++;
      $display("FAIL rst_async: got v=%b st=%0d pc=%0d expected 0 0 0",
               out_valid, state, pc);
    end
    @(negedge clock) reset = 1'b1;
    run("+.", cyc, nout, last);
    nvec++;
    if (done !== 1'b1 || nout !== 1 || last !== 8'd1 || cyc > 20) begin
      nerr++;
      $display("FAIL rst_rerun: got n=%0d d=%0d cyc=%0d expected 1 1 <=20",
               nout, last, cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      pmem[i] = 4'd0;
    test_reset();
    test_output();
    test_input();
    test_loop();
    test_skip();
    test_wrap();
    test_clear();
    test_stack_limits();
    test_reset_mid_out();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
